// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// Word-organised data memory for the memory stage of a single-cycle MIPS-style
// datapath. The byte address comes from the ALU result. Bits [1:0] are ignored,
// so every access targets the containing aligned 32-bit word. Addresses beyond
// the array read as zero, and stores to them are dropped.
//
// Stores commit on the rising clock edge. Loads are combinational. The whole
// array is cleared asynchronously while Reset_n is low.
//
// Ports:
//   Clk                input   1  system clock; writes occur on its rising edge
//   Reset_n            input   1  asynchronous active-low reset; clears all words
//   Memory_Write       input   1  write enable, sampled at the rising Clk edge
//   ALU_Result         input  32  byte address
//   Memory_Write_Data  input  32  store data (rt register value)
//   Read_Data          output 32  load data, combinational
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words; a power of two, minimum 2
//   ADDR_BITS    word-index width; must equal log2(DEPTH_WORDS)
// -----------------------------------------------------------------------------
module data_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_BITS   = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Memory_Write,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] Memory_Write_Data,
  output logic [31:0] Read_Data
);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [ADDR_BITS-1:0] word_idx;
  logic                 addr_in_range;
  logic                 unused_byte_offset;

  assign word_idx      = ALU_Result[ADDR_BITS+1:2];
  // Any set bit above the word index lies past the end of the array. Such an
  // address must not alias back onto a low word.
  assign addr_in_range = (ALU_Result[31:ADDR_BITS+2] == '0);
  // The byte offset is deliberately ignored. This gives no byte or halfword
  // access, and misaligned addresses hit the containing word.
  assign unused_byte_offset = ^ALU_Result[1:0];

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] mem_d [DEPTH_WORDS];

  // Next-state of the array: hold every word, then overlay the one store.
  always_comb begin
    // NOTE: start from a full default so every element of mem_d is assigned
    // on every path; a conditional-only assignment would infer latches.
    mem_d = mem_q;
    if (Memory_Write && addr_in_range) begin
      // NOTE: blocking assignments inside always_comb; the array state itself
      // is updated with non-blocking assignments in always_ff below.
      mem_d[word_idx] = Memory_Write_Data;
    end
  end

  // NOTE: this array has a reset because it must read back as all-zero
  // immediately after reset. That forces flip-flop storage instead of an
  // SRAM macro; a memory without that requirement would be left unreset.
  // The reset branch has priority, so a write edge that coincides with reset
  // is lost, and writes stay blocked while Reset_n is low.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  // The read comes straight from the stored words and never from
  // Memory_Write_Data. A read of the word being written shows the old value
  // until the edge and the new value after it.
  always_comb begin
    Read_Data = '0;
    if (addr_in_range) begin
      Read_Data = mem_q[word_idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//
// Directed self-checking bench for data_memory with the default geometry
// (256 words, byte addresses 0..1023). Inputs change 1 ns after a rising edge,
// and outputs are sampled 1 ns after that. Expected values are hand-computed
// constants.
// -----------------------------------------------------------------------------
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic        mem_write;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int n_checks = 0;
  int n_errors = 0;

  data_memory #(
    .DEPTH_WORDS(256),
    .ADDR_BITS  (8)
  ) dut (
    .Clk              (clk),
    .Reset_n          (rst_n),
    .Memory_Write     (mem_write),
    .ALU_Result       (alu_result),
    .Memory_Write_Data(write_data),
    .Read_Data        (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, actual, expected);
    end
  endtask

  // Drive the address, let the combinational read settle, then compare.
  task automatic read_check(input string tag, input logic [31:0] addr,
                            input logic [31:0] expected);
    alu_result = addr;
    #1;
    check(tag, read_data, expected);
  endtask

  // Single write lasting one rising edge. The task returns 1 ns after that edge
  // with the write enable dropped.
  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    mem_write  = 1'b1;
    alu_result = addr;
    write_data = data;
    @(posedge clk);
    #1;
    mem_write  = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_write  = 1'b0;
    alu_result = '0;
    write_data = '0;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: store something, then pulse reset low mid-run and release it.
    write_word(32'd64, 32'h1234_5678);
    read_check("pre_reset_64", 32'd64, 32'h1234_5678);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    read_check("reset_rd_0",   32'd0,   32'h0);
    read_check("reset_rd_64",  32'd64,  32'h0);
    read_check("reset_rd_128", 32'd128, 32'h0);
    @(posedge clk);
    #1;

    // 2: two stores, then combinational reads with no further clock.
    write_word(32'd64,  32'd45);
    write_word(32'd128, 32'd100);
    read_check("rd_64_eq_45",   32'd64,  32'd45);
    read_check("rd_128_eq_100", 32'd128, 32'd100);

    // 3: with the write enable low, several edges leave the array unchanged.
    mem_write  = 1'b0;
    alu_result = 32'd64;
    write_data = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check("we0_hold_64", read_data, 32'd45);

    // 4: a misaligned store hits the containing word.
    write_word(32'd66, 32'hA5A5_A5A5);
    read_check("misalign_rd_64", 32'd64, 32'hA5A5_A5A5);
    read_check("misalign_rd_67", 32'd67, 32'hA5A5_A5A5);
    // An out-of-range store would alias word 0 if it were not dropped.
    write_word(32'h0000_0400, 32'd7);
    read_check("oor_rd_400", 32'h0000_0400, 32'h0);
    read_check("oor_rd_0",   32'd0,         32'h0);
    // A high address bit set must not alias back onto word 16 (address 64).
    read_check("oor_rd_high", 32'h1000_0040, 32'h0);

    // 5: asynchronous reset asserted between edges clears data immediately.
    read_check("pre_areset_128", 32'd128, 32'd100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    read_check("areset_rd_128", 32'd128, 32'h0);
    read_check("areset_rd_64",  32'd64,  32'h0);
    // A write requested while reset is held must not take effect.
    mem_write  = 1'b1;
    alu_result = 32'd64;
    write_data = 32'h5555_5555;
    @(posedge clk);
    #1;
    check("write_in_reset", read_data, 32'h0);
    mem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    read_check("after_reset_64", 32'd64, 32'h0);
    @(posedge clk);
    #1;

    // 6: back-to-back stores to one word, with reads before and after edges.
    mem_write  = 1'b1;
    alu_result = 32'd8;
    write_data = 32'd1;
    @(posedge clk);
    #1;
    check("b2b_first", read_data, 32'd1);
    write_data = 32'd2;
    @(posedge clk);
    #1;
    check("b2b_second", read_data, 32'd2);
    // Pending write data must not bypass to the read before the edge.
    write_data = 32'd3;
    #1;
    check("no_bypass_pre_edge", read_data, 32'd2);
    @(posedge clk);
    #1;
    check("post_edge_new", read_data, 32'd3);
    mem_write = 1'b0;

    // Boundary: the last word in the array, and the first address past it.
    write_word(32'd1020, 32'hCAFE_F00D);
    read_check("last_word_1020", 32'd1020, 32'hCAFE_F00D);
    read_check("last_word_1023", 32'd1023, 32'hCAFE_F00D);
    write_word(32'd1024, 32'h0000_0099);
    read_check("oor_rd_1024",   32'd1024, 32'h0);
    read_check("oor_keep_0",    32'd0,    32'h0);
    read_check("oor_keep_1020", 32'd1020, 32'hCAFE_F00D);
    read_check("keep_word_8",   32'd8,    32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
Word-organised data memory for the single-cycle MIPS-style datapath, sitting after the ALU in the memory stage. The byte address comes from the ALU result. Stores are synchronous on the rising clock edge. Loads are combinational, so load data is available in the same cycle as the address. The whole array is cleared by an asynchronous active-low reset.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; must be a power of two, minimum 2.
ADDR_BITS, 8, word-index width; must equal log2(DEPTH_WORDS).

Ports:
Clk  input  1  system clock; all writes occur on its rising edge.
Reset_n  input  1  asynchronous active-low reset; clears every word.
Memory_Write  input  1  write enable, sampled at the rising Clk edge.
ALU_Result  input  32  byte address, from the ALU.
Memory_Write_Data  input  32  store data (rt register value).
Read_Data  output  32  load data, combinational.

Behaviour:
- Address decode:
  - word index = ALU_Result[ADDR_BITS+1:2].
  - ALU_Result[1:0] are ignored; a misaligned address accesses the containing aligned word. There is no byte or halfword access.
  - An address is in range when ALU_Result[31:ADDR_BITS+2] == 0. Any other address is out of range.
- Reset:
  - While Reset_n = 0, all DEPTH_WORDS words are forced to 32'h0 immediately, with no clock required.
  - Writes are blocked while Reset_n = 0.
  - A write edge that coincides with assertion of Reset_n is lost; the reset wins.
  - Writes resume on the first rising edge after Reset_n goes high.
- Write:
  - At a rising Clk edge with Reset_n = 1 and Memory_Write = 1, mem[index] <= Memory_Write_Data, only if the address is in range.
  - Out-of-range writes are silently dropped; no other word changes.
  - Memory_Write = 0 leaves the array unchanged.
- Read:
  - Read_Data = mem[index] for an in-range address, and 32'h0 for an out-of-range address.
  - Purely combinational. It follows changes in ALU_Result with no clock, and it is valid regardless of Memory_Write.
  - There is no read-enable port.
  - After reset, every in-range read returns 0.
- Read during write to the same word:
  - Before the edge, Read_Data shows the old contents.
  - After the edge, Read_Data shows the new data in the same cycle.
  - No bypass of the pending write data.
- Latency: write takes effect 1 edge after the request; read latency is 0 cycles.
- Output value during reset: 32'h0.
- Undriven or X inputs are not specified; the bench drives all inputs at all times.

Test Plan:
1. Reset_n pulsed low mid-run, then released; read addresses 0, 64 and 128 -> Read_Data = 0 for each.
2. Memory_Write = 1, ALU_Result = 64, data = 45, one edge; then ALU_Result = 128, data = 100, one edge; then Memory_Write = 0. Address 64 -> Read_Data = 45 with no further clock. Change address to 128 -> Read_Data = 100 combinationally.
3. Memory_Write = 0, ALU_Result = 64, data = 32'hDEADBEEF, several edges -> address 64 still reads 45.
4. Misaligned and out-of-range access:
   - Write 32'hA5A5A5A5 to address 66 -> reading addresses 64 and 67 both return 32'hA5A5A5A5.
   - Write 7 to address 32'h0000_0400 (out of range) -> Read_Data = 0 there, and address 0 is still 0.
5. Asynchronous reset after data is written: assert Reset_n = 0 between clock edges -> Read_Data at addresses 64 and 128 drops to 0 immediately. A write requested while Reset_n = 0 has no effect.
6. Back-to-back writes to the same word, 1 then 2 on consecutive edges -> the read shows 1 after the first edge and 2 after the second. Boundary: writing the last word (address 1020) reads back correctly, and address 1024 is treated as out of range.
